// File: rtl/game_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : game_pkg
// Brief    : Shared constants and types for the LED memory game input path.
// Revision : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam int KEY_SUBMIT            = 0;
    localparam int DEBOUNCE_CYCLES_50MHZ = 1000000;

    typedef enum logic [0:0] {
        DB_UP   = 1'b0,
        DB_DOWN = 1'b1
    } db_state_t;

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : key_debounce
// Brief    : Synchronizer plus UP/DOWN debouncer for one active-low button.
// Revision : 1.0 - initial release
// ============================================================================
module key_debounce
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic key_raw,
    output logic level,
    output logic press
);

    localparam int                 c_cnt_w    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    db_state_t              r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic                   w_key_sync;
    logic                   w_toward;

    assign w_key_sync = r_sync[SYNC_STAGES-1];
    // True while the synchronized pin sits at the level opposite the current state.
    assign w_toward   = (r_state == DB_UP) ? ~w_key_sync : w_key_sync;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync  <= '1;
            r_state <= DB_UP;
            r_cnt   <= '0;
            level   <= 1'b0;
            press   <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], key_raw};
            press  <= 1'b0;
            if (!w_toward) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt <= '0;
                if (r_state == DB_UP) begin
                    r_state <= DB_DOWN;
                    level   <= 1'b1;
                    press   <= 1'b1;
                end else begin
                    r_state <= DB_UP;
                    level   <= 1'b0;
                end
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/answer_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : answer_capture
// Brief    : Button/switch input stage; captures the switch answer on submit
//            and hands it to the game over valid/ready.
//            Optional macro ANSWER_CAPTURE_SUBMIT_COUNT_EN adds submit_cnt.
// Revision : 1.0 - initial release
// ============================================================================
module answer_capture
    import game_pkg::*;
#(
    parameter int SW_W            = 16,
    parameter int KEY_W           = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SW_W-1:0]  sw,
    input  logic [KEY_W-1:0] key,
    input  logic             capture_en,
    output logic [SW_W-1:0]  ans_data,
    output logic             ans_valid,
    input  logic             ans_ready,
    output logic [KEY_W-1:0] key_evt,
    output logic [KEY_W-1:0] key_level,
    output logic             overrun
`ifdef ANSWER_CAPTURE_SUBMIT_COUNT_EN
    ,
    output logic [7:0]       submit_cnt
`endif
);

    logic [SW_W-1:0] r_sw_sync [SYNC_STAGES];
    logic            w_submit;
    logic            w_xfer;
    logic            w_accept;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sw_sync[i] <= '0;
            end
        end else begin
            r_sw_sync[0] <= sw;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sw_sync[i] <= r_sw_sync[i-1];
            end
        end
    end

    generate
        for (genvar g = 0; g < KEY_W; g++) begin : g_key
            key_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .SYNC_STAGES     (SYNC_STAGES)
            ) u_debounce (
                .clk     (clk),
                .rst     (rst),
                .key_raw (key[g]),
                .level   (key_level[g]),
                .press   (key_evt[g])
            );
        end
    endgenerate

    assign w_submit = key_evt[KEY_SUBMIT] & capture_en;
    assign w_xfer   = ans_valid & ans_ready;
    // A submit is taken when the slot is empty or is being emptied this very edge.
    assign w_accept = w_submit & (~ans_valid | w_xfer);

    always_ff @(posedge clk) begin
        if (rst) begin
            ans_data  <= '0;
            ans_valid <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_accept) begin
                ans_data  <= r_sw_sync[SYNC_STAGES-1];
                ans_valid <= 1'b1;
            end else if (w_xfer) begin
                ans_valid <= 1'b0;
            end
            if (w_submit && ans_valid && !w_xfer) begin
                overrun <= 1'b1;
            end
        end
    end

`ifdef ANSWER_CAPTURE_SUBMIT_COUNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            submit_cnt <= 8'd0;
        end else if (w_accept && (submit_cnt != 8'hFF)) begin
            submit_cnt <= submit_cnt + 8'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_answer_capture.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_answer_capture
// Brief    : Directed self-checking bench for answer_capture (debounce = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_answer_capture;

    logic        clk;
    logic        rst;
    logic [15:0] sw;
    logic [3:0]  key;
    logic        capture_en;
    logic [15:0] ans_data;
    logic        ans_valid;
    logic        ans_ready;
    logic [3:0]  key_evt;
    logic [3:0]  key_level;
    logic        overrun;
`ifdef ANSWER_CAPTURE_SUBMIT_COUNT_EN
    logic [7:0]  submit_cnt;
`endif

    int checks = 0;
    int errors = 0;

    answer_capture #(
        .SW_W            (16),
        .KEY_W           (4),
        .SYNC_STAGES     (2),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .key        (key),
        .capture_en (capture_en),
        .ans_data   (ans_data),
        .ans_valid  (ans_valid),
        .ans_ready  (ans_ready),
        .key_evt    (key_evt),
        .key_level  (key_level),
        .overrun    (overrun)
`ifdef ANSWER_CAPTURE_SUBMIT_COUNT_EN
        ,
        .submit_cnt (submit_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cyc(2);
        rst = 1'b0;
    endtask

    // Clean press of one key: 8 cycles low, 8 cycles high (debouncer back in UP).
    task automatic press_key(input int idx);
        key[idx] = 1'b0;
        cyc(8);
        key[idx] = 1'b1;
        cyc(8);
    endtask

    task automatic test_reset();
        key = 4'hF; sw = 16'h0; capture_en = 1'b0; ans_ready = 1'b0;
        do_reset();
        checks++;
        if (ans_valid !== 1'b0 || ans_data !== 16'h0 || key_evt !== 4'h0 ||
            key_level !== 4'h0 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL reset: valid=%b data=%h evt=%b level=%b ovr=%b (want 0 0000 0000 0000 0)",
                     ans_valid, ans_data, key_evt, key_level, overrun);
        end
    endtask

    task automatic test_clean_press();
        sw = 16'hA5C3; capture_en = 1'b1; ans_ready = 1'b0;
        key[0] = 1'b0;
        for (int i = 1; i <= 27; i++) begin
            @(negedge clk);
            if (i == 10) key[0] = 1'b1;
            if (i <= 6 || (i > 7 && i < 12)) begin
                checks++;
                if (key_evt[0] !== (i == 6)) begin
                    errors++;
                    $display("FAIL clean_evt cyc %0d: got %b want %b", i, key_evt[0], (i == 6));
                end
            end
            if (i == 6) begin
                checks++;
                if (key_level[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL clean_level: got %b want 1", key_level[0]);
                end
            end
            if (i >= 7) begin
                checks++;
                if (ans_valid !== 1'b1 || ans_data !== 16'hA5C3) begin
                    errors++;
                    $display("FAIL clean_hold cyc %0d: valid=%b data=%h want 1 a5c3", i, ans_valid, ans_data);
                end
            end
        end
        ans_ready = 1'b1;
        cyc(1);
        ans_ready = 1'b0;
        checks++;
        if (ans_valid !== 1'b0) begin
            errors++;
            $display("FAIL clean_consume: valid=%b want 0", ans_valid);
        end
    endtask

    task automatic test_bounce();
        for (int i = 0; i < 20; i++) begin
            if (i < 12) key[1] = (i % 4 < 2) ? 1'b0 : 1'b1;
            else        key[1] = 1'b1;
            @(negedge clk);
            checks++;
            if (key_evt[1] !== 1'b0 || key_level[1] !== 1'b0) begin
                errors++;
                $display("FAIL bounce cyc %0d: evt=%b level=%b want 0 0", i, key_evt[1], key_level[1]);
            end
        end
    endtask

    task automatic test_handshake_overrun();
        capture_en = 1'b1; ans_ready = 1'b0;
        sw = 16'h0001;
        press_key(0);
        checks++;
        if (ans_valid !== 1'b1 || ans_data !== 16'h0001 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL hs_first: valid=%b data=%h ovr=%b want 1 0001 0", ans_valid, ans_data, overrun);
        end
        sw = 16'h00FF;
        press_key(0);
        checks++;
        if (overrun !== 1'b1 || ans_data !== 16'h0001 || ans_valid !== 1'b1) begin
            errors++;
            $display("FAIL hs_overrun: ovr=%b data=%h valid=%b want 1 0001 1", overrun, ans_data, ans_valid);
        end
        ans_ready = 1'b1;
        cyc(1);
        ans_ready = 1'b0;
        checks++;
        if (ans_valid !== 1'b0 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL hs_xfer: valid=%b ovr=%b want 0 1", ans_valid, overrun);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        capture_en = 1'b1; ans_ready = 1'b0;
        sw = 16'h1111;
        press_key(0);
        sw = 16'h2222;
        key[0] = 1'b0;
        cyc(6);
        checks++;
        if (key_evt[0] !== 1'b1) begin
            errors++;
            $display("FAIL b2b_evt: got %b want 1", key_evt[0]);
        end
        ans_ready = 1'b1;
        cyc(1);
        ans_ready = 1'b0;
        checks++;
        if (ans_valid !== 1'b1 || ans_data !== 16'h2222 || overrun !== 1'b0) begin
            errors++;
            $display("FAIL b2b_load: valid=%b data=%h ovr=%b want 1 2222 0", ans_valid, ans_data, overrun);
        end
        key[0] = 1'b1;
        cyc(8);
        ans_ready = 1'b1;
        cyc(1);
        ans_ready = 1'b0;
    endtask

    task automatic test_disabled_and_reset();
        do_reset();
        capture_en = 1'b0; ans_ready = 1'b0; sw = 16'hBEEF;
        key[0] = 1'b0;
        cyc(6);
        checks++;
        if (key_evt[0] !== 1'b1) begin
            errors++;
            $display("FAIL dis_evt: got %b want 1", key_evt[0]);
        end
        cyc(1);
        checks++;
        if (ans_valid !== 1'b0) begin
            errors++;
            $display("FAIL dis_valid: got %b want 0", ans_valid);
        end
        key[0] = 1'b1;
        cyc(8);
        // key[2] pressed; the debouncer count reaches 2 after 4 edges
        key[2] = 1'b0;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        checks++;
        if (key_evt[2] !== 1'b0 || key_level[2] !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: evt=%b level=%b want 0 0", key_evt[2], key_level[2]);
        end
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            checks++;
            if (key_evt[2] !== (i == 6)) begin
                errors++;
                $display("FAIL rst_evt cyc %0d: got %b want %b", i, key_evt[2], (i == 6));
            end
        end
        key[2] = 1'b1;
        cyc(8);
    endtask

`ifdef ANSWER_CAPTURE_SUBMIT_COUNT_EN
    task automatic test_submit_count();
        do_reset();
        capture_en = 1'b1; ans_ready = 1'b0; sw = 16'h0042;
        press_key(0);
        press_key(0);
        checks++;
        if (submit_cnt !== 8'd1 || overrun !== 1'b1) begin
            errors++;
            $display("FAIL cnt_drop: cnt=%0d ovr=%b want 1 1", submit_cnt, overrun);
        end
        ans_ready = 1'b1;
        capture_en = 1'b0;
        press_key(0);
        checks++;
        if (submit_cnt !== 8'd1) begin
            errors++;
            $display("FAIL cnt_disabled: cnt=%0d want 1", submit_cnt);
        end
        capture_en = 1'b1;
        for (int i = 0; i < 254; i++) press_key(0);
        checks++;
        if (submit_cnt !== 8'd255) begin
            errors++;
            $display("FAIL cnt_255: cnt=%0d want 255", submit_cnt);
        end
        for (int i = 0; i < 3; i++) press_key(0);
        checks++;
        if (submit_cnt !== 8'd255) begin
            errors++;
            $display("FAIL cnt_sat: cnt=%0d want 255", submit_cnt);
        end
        ans_ready = 1'b0;
    endtask
`endif

    initial begin
        rst = 1'b0; key = 4'hF; sw = 16'h0; capture_en = 1'b0; ans_ready = 1'b0;
        cyc(1);
        test_reset();
        test_clean_press();
        test_bounce();
        test_handshake_overrun();
        test_back_to_back();
        test_disabled_and_reset();
`ifdef ANSWER_CAPTURE_SUBMIT_COUNT_EN
        test_submit_count();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/answer_capture.md
Name: answer_capture

Overview:
- Player-input end of the LED memory game: the game drives LEDs out to the player, and this block brings the player's answer back in.
- Synchronizes and debounces the four push-buttons and synchronizes the 16 switches.
- On a debounced submit press, snapshots the switch pattern and offers it to the game FSM over a valid/ready handshake.
- The other buttons become single-cycle event pulses. Sits between the board pins and led_game.

Parameters:
- SW_W, 16, switch/answer width
- KEY_W, 4, number of push-buttons; key[0] = submit
- SYNC_STAGES, 2, flip-flop synchronizer depth on sw and key (min 2)
- DEBOUNCE_CYCLES, 1000000, stable cycles required before a key changes state (20 ms at 50 MHz; min 2)

Ports:
- clk  input  1  system clock, 50 MHz
- rst  input  1  synchronous active-high reset
- sw  input  SW_W  raw asynchronous switches
- key  input  KEY_W  raw asynchronous buttons, active-low (0 = pressed)
- capture_en  input  1  game is in answer phase; submits are ignored when low
- ans_data  output  SW_W  captured switch pattern
- ans_valid  output  1  ans_data holds an unconsumed answer
- ans_ready  input  1  game accepts the answer
- key_evt  output  KEY_W  1-cycle pulse per debounced press; bit 0 pulses even when the submit is ignored
- key_level  output  KEY_W  debounced pressed state, active-high
- overrun  output  1  sticky: a submit was dropped because ans_valid was already high

Behaviour:
- Reset (one clock, rst=1 at a rising edge):
  - synchronizers cleared to the idle level: key stages=1, sw stages=0
  - all debouncers go to UP with count 0
  - ans_data=0, ans_valid=0, key_evt=0, key_level=0, overrun=0
- Synchronizer: SYNC_STAGES flops per bit; downstream logic uses only the last stage.
- Debouncer, one per key; states UP and DOWN plus a counter cnt (width clog2(DEBOUNCE_CYCLES)).
  - In UP: while sync key=0, cnt increments; any cycle with sync key=1 clears cnt.
  - When cnt==DEBOUNCE_CYCLES-1 and sync key is still 0: go to DOWN, clear cnt, pulse key_evt for exactly one cycle.
  - DOWN mirrors UP with key=1 and returns to UP with no event.
  - key_level=1 in DOWN.
  - Latency from a clean pin edge to key_evt: SYNC_STAGES+DEBOUNCE_CYCLES cycles.
  - Glitches shorter than DEBOUNCE_CYCLES produce no event.
  - Holding a key produces one event only.
- Submit capture, when key_evt[0]=1 and capture_en=1:
  - If ans_valid=0: load ans_data from the synchronized sw in that cycle; set ans_valid next edge.
  - If ans_valid=1 and no transfer occurs this cycle: drop the submit, leave ans_data unchanged, set overrun=1.
  - If ans_valid=1 and ans_ready=1 in the same cycle as the submit: the transfer completes and the new answer is loaded; ans_valid stays 1 and overrun is not set.
  - capture_en is sampled only in the cycle of the submit event.
- Handshake:
  - Transfer occurs on a rising edge with ans_valid=1 and ans_ready=1; ans_valid then clears unless a new capture lands that cycle.
  - ans_data is stable while ans_valid=1.
  - ans_ready may be high while ans_valid=0 with no effect.
- overrun clears only on rst.
- Reset mid-debounce or mid-handshake discards all state; a key held through reset must be seen stable for the full DEBOUNCE_CYCLES after reset before it generates an event.
- key_evt[3:1] do not depend on capture_en.

Optional Feature:
- Macro ANSWER_CAPTURE_SUBMIT_COUNT_EN.
- Defined: adds output submit_cnt (8 bits) counting accepted captures. It saturates at 255, resets to 0, and does not count dropped or disabled submits.
- Undefined: port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package, game_pkg:
  - KEY_SUBMIT index constant (0)
  - typedef of the debouncer state enum (UP, DOWN)
  - default DEBOUNCE_CYCLES for 50 MHz
- Sub-module key_debounce (parameters DEBOUNCE_CYCLES and SYNC_STAGES; one bit in; outputs level and press pulse), instantiated KEY_W times with a generate loop.
- Switch synchronizer and capture/handshake logic live in answer_capture.

Test Plan (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2):
- Clean press: key[0] 1->0 held 10 cycles, sw=16'hA5C3, capture_en=1, ans_ready=0 -> key_evt[0] pulses once at 6 cycles after the edge; next cycle ans_valid=1, ans_data=16'hA5C3; held stable for 20 cycles.
- Bounce: key[1] toggled 0/1 every 2 cycles for 12 cycles, then 1 -> no key_evt, key_level[1]=0 throughout.
- Handshake and overrun: answer pending (0x0001); second submit with sw=0x00FF and ans_ready=0 -> overrun=1, ans_data stays 0x0001. Then ans_ready=1 for one cycle -> ans_valid=0 next cycle.
- Simultaneous events: ans_valid=1 (0x1111); submit with sw=0x2222 coincides with ans_ready=1 -> ans_valid stays 1, ans_data=0x2222, overrun=0.
- Disabled capture and reset: capture_en=0 with a submit -> key_evt[0] pulses, ans_valid stays 0. Then assert rst during a key[2] debounce count, release at cnt=2 -> no key_evt[2] until 4 full stable cycles after reset.
- Optional feature, with ANSWER_CAPTURE_SUBMIT_COUNT_EN: 258 accepted submits -> submit_cnt=255; dropped submits do not increment it.
